// File: rtl/vxe_intr_ctrl_unit_pkg.sv
// Shared constants for the CU interrupt controller: cause bit positions,
// error-cause mask and register word indices.
package vxe_intr_ctrl_unit_pkg;

    localparam int unsigned INTR_W             = 4;
    localparam int unsigned INTR_IDX_COMPLETED = 0;
    localparam int unsigned INTR_IDX_ERR_FETCH = 1;
    localparam int unsigned INTR_IDX_ERR_INSTR = 2;
    localparam int unsigned INTR_IDX_ERR_DATA  = 3;

    localparam logic [INTR_W-1:0] INTR_ERR_MASK =
        INTR_W'((1 << INTR_IDX_ERR_FETCH) | (1 << INTR_IDX_ERR_INSTR) | (1 << INTR_IDX_ERR_DATA));

    localparam logic [3:0] VXE_ICU_REG_ACT         = 4'd0;
    localparam logic [3:0] VXE_ICU_REG_MASK        = 4'd1;
    localparam logic [3:0] VXE_ICU_REG_PEND        = 4'd2;
    localparam logic [3:0] VXE_ICU_REG_FLT_ADDR_LO = 4'd3;
    localparam logic [3:0] VXE_ICU_REG_FLT_ADDR_HI = 4'd4;
    localparam logic [3:0] VXE_ICU_REG_FLT_DATA_LO = 4'd5;
    localparam logic [3:0] VXE_ICU_REG_FLT_DATA_HI = 4'd6;
    localparam logic [3:0] VXE_ICU_REG_VPU_FAULT   = 4'd7;
    localparam logic [3:0] VXE_ICU_REG_CNT         = 4'd8;
    localparam logic [3:0] VXE_ICU_REG_STATUS      = 4'd9;

    function automatic logic has_err(input logic [INTR_W-1:0] causes);
        return |(causes & INTR_ERR_MASK);
    endfunction

endpackage

// File: rtl/vxe_intr_flt_capture.sv
// First-fault context capture: latches address/data of the first error event
// and holds it until software has cleared every error cause.
module vxe_intr_flt_capture (
    input  logic        clk,
    input  logic        nrst,
    input  logic        evt_vld,
    input  logic        evt_err,
    input  logic        act_err_nxt,
    input  logic [36:0] addr,
    input  logic [63:0] data,
    output logic        lock,
    output logic [36:0] flt_addr,
    output logic [63:0] flt_data
);

    logic        lock_q, lock_d;
    logic        capture;
    logic [36:0] addr_q;
    logic [63:0] data_q;

    // A coincident clear cannot drop the lock: the new error already shows up in act_err_nxt.
    always_comb begin
        capture = evt_vld & evt_err & ~lock_q;
        lock_d  = capture | (lock_q & act_err_nxt);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lock_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            lock_q <= lock_d;
            if (capture) begin
                addr_q <= addr;
                data_q <= data;
            end
        end
    end

    assign lock     = lock_q;
    assign flt_addr = addr_q;
    assign flt_data = data_q;

endmodule

// File: rtl/vxe_intr_ctrl_unit.sv
// CU interrupt/fault receiver: sticky maskable cause status, event counter,
// first-fault context and a 32-bit register port driving a level IRQ.
module vxe_intr_ctrl_unit
    import vxe_intr_ctrl_unit_pkg::*;
#(
    parameter int unsigned VPUS_NR = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_intr_vld,
    input  logic [3:0]         i_intr,
    input  logic [36:0]        i_last_instr_addr,
    input  logic [63:0]        i_last_instr_data,
    input  logic [VPUS_NR-1:0] i_vpu_fault,
    input  logic [3:0]         i_reg_sel,
    input  logic               i_reg_rd,
    input  logic               i_reg_wr,
    input  logic [31:0]        i_reg_wdata,
    output logic [31:0]        o_reg_rdata,
    output logic               o_reg_rvld,
    output logic               o_irq
);

    logic [3:0]         act_q, act_d;
    logic [3:0]         mask_q, mask_d;
    logic [VPUS_NR-1:0] vpu_q, vpu_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic               irq_q, irq_d;
    logic               rvld_q;
    logic [31:0]        rdata_q, rdata_d, rd_val;
    logic               lock;
    logic [36:0]        flt_addr;
    logic [63:0]        flt_data;
    logic               wr_act, wr_mask, wr_vpu, wr_cnt;
    logic               unused_wdata;

    assign unused_wdata = ^i_reg_wdata;

    always_comb begin
        wr_act  = i_reg_wr && (i_reg_sel == VXE_ICU_REG_ACT);
        wr_mask = i_reg_wr && (i_reg_sel == VXE_ICU_REG_MASK);
        wr_vpu  = i_reg_wr && (i_reg_sel == VXE_ICU_REG_VPU_FAULT);
        wr_cnt  = i_reg_wr && (i_reg_sel == VXE_ICU_REG_CNT);

        // Clears apply first so a same-cycle event always wins.
        act_d = act_q & ~(wr_act ? i_reg_wdata[3:0] : 4'h0);
        vpu_d = vpu_q & ~(wr_vpu ? i_reg_wdata[VPUS_NR-1:0] : {VPUS_NR{1'b0}});
        if (i_intr_vld) begin
            act_d = act_d | i_intr;
            vpu_d = vpu_d | i_vpu_fault;
        end

        mask_d = wr_mask ? i_reg_wdata[3:0] : mask_q;

        cnt_base = wr_cnt ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (i_intr_vld && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base + CNT_W'(1);
        end

        irq_d = |(act_d & mask_d);
    end

    always_comb begin
        rd_val = '0;
        case (i_reg_sel)
            VXE_ICU_REG_ACT:         rd_val[3:0] = act_q;
            VXE_ICU_REG_MASK:        rd_val[3:0] = mask_q;
            VXE_ICU_REG_PEND:        rd_val[3:0] = act_q & mask_q;
            VXE_ICU_REG_FLT_ADDR_LO: rd_val = flt_addr[31:0];
            VXE_ICU_REG_FLT_ADDR_HI: rd_val[4:0] = flt_addr[36:32];
            VXE_ICU_REG_FLT_DATA_LO: rd_val = flt_data[31:0];
            VXE_ICU_REG_FLT_DATA_HI: rd_val = flt_data[63:32];
            VXE_ICU_REG_VPU_FAULT:   rd_val[VPUS_NR-1:0] = vpu_q;
            VXE_ICU_REG_CNT:         rd_val[CNT_W-1:0] = cnt_q;
            VXE_ICU_REG_STATUS:      rd_val[1:0] = {irq_q, lock};
            default:                 rd_val = '0;
        endcase
        rdata_d = i_reg_rd ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            act_q   <= '0;
            mask_q  <= '0;
            vpu_q   <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            rvld_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            act_q   <= act_d;
            mask_q  <= mask_d;
            vpu_q   <= vpu_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            rvld_q  <= i_reg_rd;
            rdata_q <= rdata_d;
        end
    end

    vxe_intr_flt_capture u_flt_capture (
        .clk         (clk),
        .nrst        (nrst),
        .evt_vld     (i_intr_vld),
        .evt_err     (has_err(i_intr)),
        .act_err_nxt (has_err(act_d)),
        .addr        (i_last_instr_addr),
        .data        (i_last_instr_data),
        .lock        (lock),
        .flt_addr    (flt_addr),
        .flt_data    (flt_data)
    );

    assign o_reg_rdata = rdata_q;
    assign o_reg_rvld  = rvld_q;
    assign o_irq       = irq_q;

endmodule

// File: doc/vxe_intr_ctrl_unit.md
Name: vxe_intr_ctrl_unit

Overview:
- Receiving end of the CU interrupt/fault reporting interface.
- Accepts the one-cycle interrupt event (valid plus 4-bit cause vector) together with fault context: last instruction address/data and per-VPU fault bits.
- Accumulates causes into sticky, maskable status and drives a level interrupt line to the host.
- Exposes status, mask, fault context and an event counter through a simple 32-bit register port for driver software.

Parameters:
- VPUS_NR, 2, number of VPUs (1..32); width of the VPU fault vector.
- CNT_W, 16, width of the saturating interrupt-event counter (1..32).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- i_intr_vld  in  1  one-cycle interrupt event strobe from CU
- i_intr  in  4  cause vector, bit positions INTR_IDX_COMPLETED/ERR_FETCH/ERR_INSTR/ERR_DATA; sampled only with i_intr_vld
- i_last_instr_addr  in  37  faulting instruction address
- i_last_instr_data  in  64  faulting instruction word
- i_vpu_fault  in  VPUS_NR  per-VPU data fault bits
- i_reg_sel  in  4  register word index
- i_reg_rd  in  1  read request
- i_reg_wr  in  1  write request; rd and wr are never asserted together
- i_reg_wdata  in  32  write data
- o_reg_rdata  out  32  read data
- o_reg_rvld  out  1  read data valid
- o_irq  out  1  level interrupt to host

Behaviour:
- Reset (async, nrst low): act=0, mask=0, vpu_flt=0, lock=0, cnt=0, flt_addr=0, flt_data=0, o_irq=0, o_reg_rvld=0, o_reg_rdata=0. Reset mid-operation discards everything, including a pending read.
- Event accept: on i_intr_vld, act |= i_intr and vpu_flt |= i_vpu_fault.
  - cnt increments by 1 and saturates at all-ones.
  - An event with i_intr==0 still counts.
- First-fault capture:
  - If i_intr_vld, the event has any error bit (FETCH, INSTR or DATA) and lock==0: latch flt_addr/flt_data and set lock=1.
  - While lock==1, later events do not overwrite flt_addr/flt_data.
  - lock clears in the cycle in which all three error bits of act become 0.
  - If a clear and a new error event coincide, the set wins, lock stays 1 and the context is not re-latched.
- Register map (word index; unlisted indices read 0 and ignore writes):
  - 0 INTR_ACT [3:0]: write-1-to-clear.
  - 1 INTR_MASK [3:0]: read/write.
  - 2 INTR_PEND [3:0] = act & mask: read-only.
  - 3 FLT_ADDR_LO [31:0].
  - 4 FLT_ADDR_HI [4:0].
  - 5 FLT_DATA_LO.
  - 6 FLT_DATA_HI. Indices 3..6 are read-only.
  - 7 VPU_FAULT [VPUS_NR-1:0]: write-1-to-clear.
  - 8 INTR_CNT [CNT_W-1:0]: any write clears it to 0.
  - 9 STATUS: bit0=lock, bit1=o_irq; read-only.
- Simultaneous events:
  - W1C and a same-cycle i_intr_vld setting the same bit: the bit ends at 1.
  - Counter clear and a same-cycle event: cnt ends at 1.
- Reads:
  - o_reg_rvld pulses exactly 1 cycle after i_reg_rd.
  - o_reg_rdata holds the register value as of the rd cycle, before any same-cycle update.
  - o_reg_rdata holds its value until the next read.
- Writes take effect on the next clock edge. There is no write response.
- Interrupt line: o_irq is registered; o_irq = |(act & mask) evaluated on post-update state. Latency is 1 cycle from i_intr_vld or mask write to o_irq rising, and 1 cycle from clear to o_irq falling.
- Unused upper bits of every register read as 0.

Decomposition:
- Reuse the shared header vxe_intr_params.vh for the INTR_IDX_* constants.
- Add register word-index constants (VXE_ICU_REG_*) and an error-bit mask constant to a new shared header, vxe_intr_ctrl_regs.vh, shared with software tests.
- One natural sub-module: vxe_intr_flt_capture, holding the lock plus address/data capture logic. Status, mask, counter and the register port stay in the top module.

Test Plan:
- Completion, masked: mask=0, event i_intr=1<<COMPLETED -> act reads 0x1<<COMPLETED, PEND=0, o_irq stays 0. Then write mask=0xF -> o_irq=1 one cycle later. W1C that bit -> o_irq=0 one cycle later.
- First-fault lock: event ERR_FETCH with addr 0x1_0000_0040, then event ERR_INSTR with addr 0x0_0000_0080 and data 0xDEADBEEF_00C0FFEE -> FLT_ADDR_LO=0x00000040, FLT_ADDR_HI=0x1, STATUS.lock=1. W1C both bits -> lock=0. Next ERR_INSTR event re-latches.
- Data fault accumulation (VPUS_NR=2): events with i_vpu_fault=2'b01 then 2'b10 and ERR_DATA -> VPU_FAULT=0x3. Write 0x1 -> reads 0x2.
- Set/clear collision: W1C INTR_ACT=0xF in the same cycle as an event with i_intr=1<<ERR_DATA -> act=1<<ERR_DATA, lock=1, o_irq=1 when masked in.
- Counter: CNT_W=4, 20 events -> INTR_CNT=0xF. Write during an event -> reads 1.
- Async reset asserted while o_reg_rvld is due and o_irq=1 -> all outputs 0 immediately. Post-reset reads of all indices 0..15 return 0.
